mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Sequencing controller that time-multiplexes one shared FP16 multiplier and one pipelined FP16 accumulator across NUM_PAIRS operand pairs.
- The operand pairs are held in an external operand register file; this block drives its index.
- Issues the multiplier start/finish handshakes, pushes each product into the accumulator, drains the accumulator pipeline, captures the final sum and signals completion.
- Replaces the fixed 12-multiplier fan-in with a single-resource schedule.

Parameters:
NUM_PAIRS, 12, number of A/B operand pairs per dot product (1..2**IDX_W).
IDX_W, 4, width of operand index.
ACC_LAT, 2, accumulator latency in cycles from last acc_en to valid acc_sum (>=1).
MUL_TIMEOUT, 15, max MUL_WAIT cycles before fault (used only with the optional feature).

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  request a new dot product; sampled only in IDLE.
abort  in  1  synchronous cancel; any state returns to IDLE next cycle.
busy  out  1  high from cycle after start accepted through DONE cycle.
done  out  1  one-cycle completion pulse.
err  out  1  fault flag, valid with done (optional feature only; else tied 0).
result  out  16  final FP16 sum, held until next capture.
op_idx  out  IDX_W  operand pair select to the operand register file.
mul_start  out  1  one-cycle multiply request.
mul_finish  in  1  multiplier completion strobe.
mul_p  in  16  FP16 product, valid when mul_finish=1.
acc_clr  out  1  one-cycle accumulator clear.
acc_en  out  1  accumulate strobe.
acc_din  out  16  FP16 addend, valid with acc_en.
acc_sum  in  16  accumulator output.

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, err, mul_start, acc_clr, acc_en = 0; op_idx, acc_din, result, product reg, counters = 0.
- FSM states: IDLE, CLEAR, ISSUE, WAIT, PUSH, DRAIN, DONE. All strobes are Moore, registered, and decoded from state.
- IDLE: start=1 -> CLEAR; idx<=0. Otherwise stay.
- CLEAR: acc_clr=1 for 1 cycle -> ISSUE.
- ISSUE: mul_start=1 for 1 cycle; op_idx=idx, held stable from ISSUE through PUSH -> WAIT.
- WAIT: mul_finish sampled only in this state. A finish in the ISSUE cycle is ignored. mul_finish=1 -> capture mul_p into product reg -> PUSH.
- PUSH: acc_en=1, acc_din=product reg, for 1 cycle.
  - If idx==NUM_PAIRS-1 -> DRAIN, drain_cnt<=ACC_LAT-1.
  - Else idx<=idx+1 -> ISSUE.
- DRAIN: lasts exactly ACC_LAT cycles. In the cycle drain_cnt==0, result<=acc_sum -> DONE. Otherwise drain_cnt decrements.
- DONE: done=1, busy=1 for 1 cycle -> IDLE.
- Latency: with mul_finish arriving M cycles after mul_start (M>=1), done asserts at edge 1 + NUM_PAIRS*(M+2) + ACC_LAT + 1 after the start-sampling edge.
- start while busy: ignored, no queuing. start and abort together in IDLE: abort wins, stay IDLE.
- abort: next state IDLE from any state. No done pulse. Strobes drop next cycle. result unchanged. idx<=0. A late mul_finish seen in IDLE is ignored.
- acc_din holds its last value when acc_en=0.
- op_idx never exceeds NUM_PAIRS-1.
- No arithmetic is performed on FP16 values; the block only routes them.

Optional Feature:
- Macro: MAC_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter resets on entry to WAIT and increments each WAIT cycle.
  - If it reaches MUL_TIMEOUT with no mul_finish: result<=16'h7E00 (qNaN), err<=1 -> DONE (done pulse with err=1).
  - err clears when the next start is accepted.
- Undefined:
  - No counter; WAIT can last indefinitely; err constant 0; MUL_TIMEOUT is unused.

Test Plan:
- Reset mid-PUSH (rst pulse between clock edges) -> all outputs 0 immediately, state IDLE, no further mul_start.
- NUM_PAIRS=12, ACC_LAT=2, model mul_finish M=1 cycle, mul_p=16'h3C00 (1.0), model acc returns 16'h4A00 -> done at edge 40 after start; result=16'h4A00; exactly 12 mul_start, 12 acc_en, 1 acc_clr; op_idx sequence 0..11.
- Variable latency M=1,3,7 per pair alternating -> done edge matches formula sum; acc_din equals each captured mul_p in order.
- abort asserted in 5th WAIT -> IDLE next cycle, no done, result keeps previous value 16'h4A00; new start runs fully from idx 0 with acc_clr.
- start held high through a whole run plus start pulse during DRAIN -> single run, single done; a second run begins only when start is seen in IDLE.
- MAC_SEQ_TIMEOUT_EN defined, mul_finish never asserted -> done with err=1 and result=16'h7E00 after MUL_TIMEOUT WAIT cycles; next start clears err. Undefined build: the controller stays in WAIT and busy stays 1.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - single-multiplier, single-accumulator FP16 dot-product sequencer
//
// Purpose: walks NUM_PAIRS operand pairs through one shared FP16 multiplier and
// one pipelined FP16 accumulator, drains the accumulator and captures the sum.
// FP16 values are only routed, never computed on.
//
// Optional feature macro: MAC_SEQ_TIMEOUT_EN (multiplier wait timeout + err flag).
//
// Ports:
//   clk, rst            clock (posedge), asynchronous active-high reset
//   start, abort        run request (sampled in IDLE), synchronous cancel
//   busy, done, err     run in progress, one-cycle completion, timeout fault
//   result              captured FP16 sum, held until the next capture
//   op_idx              operand pair select to the operand register file
//   mul_start           one-cycle multiply request
//   mul_finish, mul_p   multiplier completion strobe and product
//   acc_clr, acc_en     accumulator clear / accumulate strobes
//   acc_din             addend to the accumulator
//   acc_sum             accumulator output
module mac_seq_ctrl #(
  parameter int NUM_PAIRS   = 12,
  parameter int IDX_W       = 4,
  parameter int ACC_LAT     = 2,
  parameter int MUL_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      result,
  output logic [IDX_W-1:0] op_idx,
  output logic             mul_start,
  input  logic             mul_finish,
  input  logic [15:0]      mul_p,
  output logic             acc_clr,
  output logic             acc_en,
  output logic [15:0]      acc_din,
  input  logic [15:0]      acc_sum
);

  localparam int DRN_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_WAIT,
    S_PUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [15:0]        product_q, product_d;
  logic [15:0]        result_q, result_d;
  logic               busy_q, done_q, mul_start_q, acc_clr_q, acc_en_q;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int WT_W = $clog2(MUL_TIMEOUT + 1);
  logic [WT_W-1:0]    wait_q, wait_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    product_d = product_q;
    result_d  = result_q;
`ifdef MAC_SEQ_TIMEOUT_EN
    wait_d    = wait_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          idx_d   = '0;
`ifdef MAC_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MAC_SEQ_TIMEOUT_EN
        wait_d  = '0;
`endif
      end
      S_WAIT: begin
        if (mul_finish) begin
          product_d = mul_p;
          state_d   = S_PUSH;
        end
`ifdef MAC_SEQ_TIMEOUT_EN
        // wait_q counts WAIT cycles already spent, so this fires on the
        // MUL_TIMEOUT-th cycle without a finish.
        else if (wait_q == WT_W'(MUL_TIMEOUT - 1)) begin
          result_d = 16'h7E00;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      S_PUSH: begin
        if (idx_q == IDX_W'(NUM_PAIRS - 1)) begin
          state_d = S_DRAIN;
          drain_d = DRN_W'(ACC_LAT - 1);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          result_d = acc_sum;
          state_d  = S_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort beats everything, including a same-cycle start or timeout capture.
    if (abort) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      product_d = product_q;
      result_d  = result_q;
`ifdef MAC_SEQ_TIMEOUT_EN
      err_d     = err_q;
`endif
    end
  end

  // Strobes are decoded from the next state so they line up with the state
  // register while still coming straight out of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      drain_q     <= '0;
      product_q   <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      product_q   <= product_d;
      result_q    <= result_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      mul_start_q <= (state_d == S_ISSUE);
      acc_clr_q   <= (state_d == S_CLEAR);
      acc_en_q    <= (state_d == S_PUSH);
    end
  end

`ifdef MAC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  // Timeout limit only matters when the wait counter exists.
  logic unused_timeout;
  assign unused_timeout = ^MUL_TIMEOUT;
  assign err = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign op_idx    = idx_q;
  assign mul_start = mul_start_q;
  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  // product_q only changes on entry to PUSH, so it already holds between pushes.
  assign acc_din   = product_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - randomized self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;

  localparam int NP = 12;
  localparam int IW = 4;
  localparam int AL = 2;
  localparam int MT = 15;

  logic          clk = 1'b0;
  logic          rst, start, abort, mul_finish;
  logic [15:0]   mul_p, acc_sum;
  logic          busy, done, err, mul_start, acc_clr, acc_en;
  logic [15:0]   result, acc_din;
  logic [IW-1:0] op_idx;

  int errs = 0;
  int checks = 0;

  int          lat[NP];
  logic [15:0] prod[NP];
  int          g_done_k;

  mac_seq_ctrl #(
    .NUM_PAIRS(NP), .IDX_W(IW), .ACC_LAT(AL), .MUL_TIMEOUT(MT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err), .result(result),
    .op_idx(op_idx), .mul_start(mul_start), .mul_finish(mul_finish),
    .mul_p(mul_p), .acc_clr(acc_clr), .acc_en(acc_en),
    .acc_din(acc_din), .acc_sum(acc_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mul_start"}, mul_start, 0);
    chk({tag, "_acc_clr"}, acc_clr, 0);
    chk({tag, "_acc_en"}, acc_en, 0);
    chk({tag, "_op_idx"}, op_idx, 0);
    chk({tag, "_acc_din"}, acc_din, 0);
    chk({tag, "_result"}, result, 0);
  endtask

  // mode: 0 normal, 1 start held high, 2 abort in 5th WAIT,
  //       3 reset during 3rd PUSH, 4 multiplier never finishes
  task automatic run_dot(input int mode, input logic [15:0] accv);
    int k, cd, pi, n_ms, n_ae, n_clr, n_done, done_k, busy_low, tail, ab_k, exp_k;
    logic ab_pend, err_seen;
    logic [IW-1:0] idxq[$];
    logic [IW-1:0] aeidxq[$];
    logic [15:0]   dinq[$];
    k = 0; cd = 0; pi = 0; n_ms = 0; n_ae = 0; n_clr = 0; n_done = 0;
    done_k = -1; busy_low = 0; tail = -1; ab_k = 0; ab_pend = 1'b0; err_seen = 1'b0;
    acc_sum = accv;
    start = 1'b1;
    @(posedge clk); #1;
    if (mode != 1) start = 1'b0;
    while (k < 1000 && tail != 0) begin
      k++;
      abort = 1'b0;
      if (k == 1) begin
        chk("busy_after_start", busy, 1);
        chk("err_clear_on_start", err, 0);
      end
      if (ab_k > 0 && k == ab_k + 1) begin
        chk("abort_busy", busy, 0);
        chk("abort_op_idx", op_idx, 0);
        chk("abort_mul_start", mul_start, 0);
      end
      if (!busy && done_k < 0 && ab_k == 0 && mode != 3) busy_low++;
      if (acc_clr) n_clr++;
      if (mul_start) begin
        n_ms++;
        idxq.push_back(op_idx);
        if (mode == 2 && n_ms == 5) ab_pend = 1'b1;
      end
      if (acc_en) begin
        n_ae++;
        dinq.push_back(acc_din);
        aeidxq.push_back(op_idx);
      end
      if (done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          err_seen = err;
        end
        start = 1'b0;
        tail = 5;
      end
      if (ab_pend && !mul_start) begin
        abort = 1'b1;
        ab_pend = 1'b0;
        ab_k = k;
        tail = 10;
      end
      // multiplier model: finish M cycles after the start it answers
      mul_finish = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mul_finish = 1'b1;
          mul_p = (pi < NP) ? prod[pi] : 16'hDEAD;
          pi++;
        end
      end
      if (mul_start && mode != 4) cd = (pi < NP) ? lat[pi] : 1;
      if (mode == 3 && acc_en && n_ae == 3) begin
        #2 rst = 1'b1;
        #1 zero_chk("rst_push");
        @(posedge clk); #1;
        rst = 1'b0;
        cd = 0;
        mul_finish = 1'b0;
        tail = 7;
      end
`ifndef MAC_SEQ_TIMEOUT_EN
      if (mode == 4 && k == 100) begin
        chk("stuck_wait_busy", busy, 1);
        tail = 1;
      end
`endif
      if (tail > 0) tail--;
      @(posedge clk); #1;
    end
    mul_finish = 1'b0;
    abort = 1'b0;
    g_done_k = done_k;

    case (mode)
      0, 1: begin
        exp_k = 1 + AL + 1;
        for (int i = 0; i < NP; i++) exp_k += lat[i] + 2;
        chk("done_edge", done_k, exp_k);
        chk("done_count", n_done, 1);
        chk("result", result, accv);
        chk("err_at_done", err_seen, 0);
        chk("mul_start_count", n_ms, NP);
        chk("acc_en_count", n_ae, NP);
        chk("acc_clr_count", n_clr, 1);
        chk("busy_gaps", busy_low, 0);
        chk("busy_after_run", busy, 0);
        for (int i = 0; i < idxq.size() && i < NP; i++) chk("op_idx_issue", idxq[i], i);
        for (int i = 0; i < aeidxq.size() && i < NP; i++) chk("op_idx_push", aeidxq[i], i);
        for (int i = 0; i < dinq.size() && i < NP; i++) chk("acc_din", dinq[i], prod[i]);
      end
      2: begin
        chk("abort_no_done", n_done, 0);
        chk("abort_result_kept", result, accv);
        chk("abort_mul_start_count", n_ms, 5);
        chk("abort_acc_en_count", n_ae, 4);
        chk("abort_idle", busy, 0);
      end
      3: begin
        chk("rst_no_more_issue", n_ms, 3);
        chk("rst_no_done", n_done, 0);
        chk("rst_idle", busy, 0);
        chk("rst_result", result, 0);
      end
      default: begin
`ifdef MAC_SEQ_TIMEOUT_EN
        chk("timeout_done_edge", done_k, 3 + MT);
        chk("timeout_err", err_seen, 1);
        chk("timeout_result", result, 16'h7E00);
        chk("timeout_acc_en", n_ae, 0);
        chk("timeout_err_held", err, 1);
`else
        chk("stuck_no_done", n_done, 0);
        chk("stuck_err", err, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("stuck_abort_idle", busy, 0);
`endif
      end
    endcase
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mul_finish = 1'b0;
    mul_p = 16'h0; acc_sum = 16'h0;
    repeat (3) @(posedge clk);
    #1 zero_chk("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NP; i++) begin
      lat[i] = 1;
      prod[i] = 16'h3C00;
    end
    run_dot(0, 16'h4A00);
    chk("directed_edge40", g_done_k, 40);

    for (int i = 0; i < NP; i++) lat[i] = 3;
    run_dot(2, 16'h4A00);

    for (int i = 0; i < NP; i++) begin
      lat[i] = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 3 : 7);
      prod[i] = 16'($urandom);
    end
    run_dot(0, 16'($urandom));

    for (int i = 0; i < NP; i++) begin
      lat[i] = $urandom_range(1, 4);
      prod[i] = 16'($urandom);
    end
    run_dot(1, 16'($urandom));

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NP; i++) begin
        lat[i] = $urandom_range(1, 7);
        prod[i] = 16'($urandom);
      end
      run_dot(0, 16'($urandom));
    end

    for (int i = 0; i < NP; i++) lat[i] = $urandom_range(1, 3);
    run_dot(3, 16'h1111);

    run_dot(4, 16'h2222);

    for (int i = 0; i < NP; i++) begin
      lat[i] = $urandom_range(1, 5);
      prod[i] = 16'($urandom);
    end
    run_dot(0, 16'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
